yarp_fetch: RTL and testbench



---
 rtl/yarp_pkg.sv | 29 ++
 rtl/yarp_fetch_buf.sv | 71 +++++++
 rtl/yarp_fetch.sv | 178 +++++++++++++++++
 tb/tb_yarp_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp pipeline front end.
package yarp_pkg;

  localparam int XLEN = 32;

  // Instruction queue depth between fetch and decode.
  localparam int BUF_DEPTH = 2;

  // Byte stride between consecutive instruction words.
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/yarp_fetch_buf.sv
// Two-entry instruction queue between fetch and decode.
// flush wins over push; a pop in the same cycle as a flush is simply absorbed.
// The head reads as all-zero whenever the queue is empty, so no leftover
// entry is ever visible downstream.
module yarp_fetch_buf
  import yarp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [BUF_DEPTH];
  fetch_entry_t mem_d [BUF_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    // The fetch FSM reserves space before issuing, so a push into a full
    // queue never happens; the guard only keeps the pointers consistent.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Queue registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/yarp_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem request channel,
// 2-entry queue towards decode, redirect handling with stale-response drop.
// Build option: define YARP_FETCH_PERF_EN to add fetch_cnt_o / drop_cnt_o.
//
// state      | meaning
// FETCH_IDLE | no request in flight; waiting for fetch_en_i and queue space
// FETCH_REQ  | imem_req_o held at fetch_pc until accepted
// FETCH_WAIT | one request accepted; waiting for its response
// FETCH_DROP | response in flight belongs to a redirected-away path; discard it
module yarp_fetch
  import yarp_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
`ifdef YARP_FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     drop_cnt_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            accept;
  logic            pop;
  logic            push;
  logic            flush;
  logic            drop_resp;
  logic            space_after_push;
  logic [1:0]      buf_count;
  fetch_entry_t    buf_head;
  fetch_entry_t    push_entry;

  assign imem_req_o    = (state_q == FETCH_REQ);
  assign imem_addr_o   = fetch_pc_q;
  assign accept        = imem_req_o && imem_ready_i;
  assign instr_valid_o = (buf_count != 2'd0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign instr_o       = buf_head.instr;
  assign pc_o          = buf_head.pc;

  // A response may only re-arm a request if the queue still has room once it
  // is written, crediting a pop by decode in the same cycle.
  assign space_after_push = (buf_count == 2'd0) ||
                            ((buf_count == 2'd1) && pop);

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = imem_rdata_i;

  // Next-state, PC update and queue control; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    drop_resp  = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        if (fetch_en_i && (buf_count != 2'd2)) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (accept) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + INSTR_BYTES;
          state_d    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          push    = 1'b1;
          state_d = (fetch_en_i && space_after_push) ? FETCH_REQ : FETCH_IDLE;
        end
      end
      FETCH_DROP: begin
        if (imem_rvalid_i) begin
          drop_resp = 1'b1;
          state_d   = FETCH_REQ;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (redirect_i) begin
      flush      = 1'b1;
      push       = 1'b0;
      fetch_pc_d = word_align(redirect_pc_i);
      unique case (state_q)
        FETCH_IDLE: state_d = FETCH_REQ;
        FETCH_REQ:  state_d = accept ? FETCH_DROP : FETCH_REQ;
        FETCH_WAIT: begin
          if (imem_rvalid_i) begin
            drop_resp = 1'b1;
            state_d   = FETCH_REQ;
          end else begin
            state_d   = FETCH_DROP;
          end
        end
        // In DROP the stale response is still owed; only the target moves.
        FETCH_DROP: state_d = state_d;
        default:    state_d = FETCH_IDLE;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  yarp_fetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (buf_count),
    .head       (buf_head)
  );

`ifdef YARP_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]  flushed_n;
  logic [1:0]  drop_inc;

  // Flushed entries exclude one that decode takes in the same cycle.
  always_comb begin
    flushed_n   = flush ? (buf_count - {1'b0, pop}) : 2'd0;
    drop_inc    = flushed_n + {1'b0, drop_resp};
    fetch_cnt_d = fetch_cnt_q + {31'd0, pop};
    drop_cnt_d  = drop_cnt_q + {30'd0, drop_inc};
  end

  // Performance counters; both wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_yarp_fetch.sv
// Directed bench for yarp_fetch. Memory answers with rdata = addr ^ 32'hA5A5_0000.
module tb_yarp_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i = 1'b0;
`ifdef YARP_FETCH_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] drop_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] acc_q[$];
  logic [31:0] dec_pc_q[$];
  logic [31:0] dec_in_q[$];
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        auto_resp = 1'b1;

  yarp_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en_i    (fetch_en_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
`ifdef YARP_FETCH_PERF_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .drop_cnt_o    (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Logs accepts and
  // decode handshakes, and plays the memory: response one cycle after accept.
  task automatic cyc();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_o && imem_ready_i;
    a   = imem_addr_o;
    if (instr_valid_o && instr_ready_i) begin
      dec_pc_q.push_back(pc_o);
      dec_in_q.push_back(instr_o);
    end
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    if (acc) begin
      acc_q.push_back(a);
      pend      = 1'b1;
      pend_addr = a;
    end
    if (pend && auto_resp) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pend_addr ^ KEY;
      pend          = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    fetch_en_i    = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_ready_i  = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    pend          = 1'b0;
    auto_resp     = 1'b1;
    acc_q.delete();
    dec_pc_q.delete();
    dec_in_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_req",   {31'd0, imem_req_o},    32'd0);
    check("rst_addr",  imem_addr_o,            32'h0000_1000);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o,                32'd0);
    check("rst_pc",    pc_o,                   32'd0);

    // Streaming fetch
    fetch_en_i = 1'b1; imem_ready_i = 1'b1; instr_ready_i = 1'b1;
    repeat (14) cyc();
    check("stream_acc0", acc_q[0], 32'h0000_1000);
    check("stream_acc1", acc_q[1], 32'h0000_1004);
    check("stream_acc2", acc_q[2], 32'h0000_1008);
    check("stream_dpc0", dec_pc_q[0], 32'h0000_1000);
    check("stream_dpc1", dec_pc_q[1], 32'h0000_1004);
    check("stream_dpc2", dec_pc_q[2], 32'h0000_1008);
    check("stream_din0", dec_in_q[0], 32'hA5A5_1000);
    check("stream_din1", dec_in_q[1], 32'hA5A5_1004);
    check("stream_din2", dec_in_q[2], 32'hA5A5_1008);

    // Decode stalled: queue fills with two entries, issue stops
    do_reset();
    fetch_en_i = 1'b1; imem_ready_i = 1'b1; instr_ready_i = 1'b0;
    repeat (10) cyc();
    check("full_nacc",  acc_q.size(),            32'd2);
    check("full_req",   {31'd0, imem_req_o},     32'd0);
    check("full_valid", {31'd0, instr_valid_o},  32'd1);
    check("full_pc",    pc_o,                    32'h0000_1000);
    check("full_instr", instr_o,                 32'hA5A5_1000);
    instr_ready_i = 1'b1;
    repeat (4) cyc();
    check("resume_acc", acc_q[2],    32'h0000_1008);
    check("resume_d0",  dec_pc_q[0], 32'h0000_1000);
    check("resume_d1",  dec_pc_q[1], 32'h0000_1004);

    // Memory back-pressure: request held stable until accepted
    do_reset();
    fetch_en_i = 1'b1; imem_ready_i = 1'b0; instr_ready_i = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("hold_req",  {31'd0, imem_req_o}, 32'd1);
      check("hold_addr", imem_addr_o,         32'h0000_1000);
      cyc();
    end
    imem_ready_i = 1'b1;
    check("hold_req4",  {31'd0, imem_req_o}, 32'd1);
    check("hold_addr4", imem_addr_o,         32'h0000_1000);
    cyc();
    check("hold_nacc",    acc_q.size(),        32'd1);
    check("hold_req_off", {31'd0, imem_req_o}, 32'd0);

    // Redirect while waiting for a response
    do_reset();
    fetch_en_i = 1'b1; imem_ready_i = 1'b1; instr_ready_i = 1'b1; auto_resp = 1'b0;
    cyc();
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_2002;
    cyc();
    redirect_i = 1'b0;
    check("rdw_drop_req", {31'd0, imem_req_o}, 32'd0);
    auto_resp = 1'b1;
    cyc();
    check("rdw_valid0", {31'd0, instr_valid_o}, 32'd0);
    cyc();
    check("rdw_req",    {31'd0, imem_req_o},    32'd1);
    check("rdw_addr",   imem_addr_o,            32'h0000_2000);
    check("rdw_valid1", {31'd0, instr_valid_o}, 32'd0);
    cyc();
    check("rdw_valid2", {31'd0, instr_valid_o}, 32'd0);
    cyc();
    check("rdw_valid3", {31'd0, instr_valid_o}, 32'd1);
    check("rdw_pc",     pc_o,                   32'h0000_2000);
    check("rdw_instr",  instr_o,                32'hA5A5_2000);
`ifdef YARP_FETCH_PERF_EN
    check("rdw_dropcnt", drop_cnt_o, 32'd1);
`endif

    // Redirect coinciding with an accept
    do_reset();
    fetch_en_i = 1'b1; imem_ready_i = 1'b1; instr_ready_i = 1'b1;
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_3000;
    cyc();
    redirect_i = 1'b0;
    check("rda_drop_req", {31'd0, imem_req_o}, 32'd0);
    cyc();
    check("rda_req",  {31'd0, imem_req_o}, 32'd1);
    check("rda_addr", imem_addr_o,         32'h0000_3000);
    cyc();
    cyc();
    check("rda_valid", {31'd0, instr_valid_o}, 32'd1);
    check("rda_pc",    pc_o,                   32'h0000_3000);
    check("rda_instr", instr_o,                32'hA5A5_3000);
    fetch_en_i = 1'b0;
    repeat (4) cyc();
    check("rda_acc1",  acc_q[1],    32'h0000_3000);
    check("rda_first", dec_pc_q[0], 32'h0000_3000);

    // PC wrap at the top of the address space, then reset mid-WAIT
    do_reset();
    fetch_en_i = 1'b1; imem_ready_i = 1'b1; instr_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    redirect_i = 1'b0;
    check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    cyc();
    cyc();
    check("wrap_req",   {31'd0, imem_req_o},    32'd1);
    check("wrap_addr1", imem_addr_o,            32'h0000_0000);
    check("wrap_valid", {31'd0, instr_valid_o}, 32'd1);
    check("wrap_pc",    pc_o,                   32'hFFFF_FFFC);
    check("wrap_instr", instr_o,                32'h5A5A_FFFC);
    auto_resp = 1'b0;
    cyc();
    check("midw_req", {31'd0, imem_req_o}, 32'd0);
    reset = 1'b1;
    pend  = 1'b0;
    #1;
    check("midrst_req",   {31'd0, imem_req_o},    32'd0);
    check("midrst_addr",  imem_addr_o,            32'h0000_1000);
    check("midrst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("midrst_instr", instr_o,                32'd0);
    check("midrst_pc",    pc_o,                   32'd0);
`ifdef YARP_FETCH_PERF_EN
    check("midrst_fcnt", fetch_cnt_o, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    auto_resp = 1'b1;
    cyc();
    check("post_rst_req",  {31'd0, imem_req_o}, 32'd1);
    check("post_rst_addr", imem_addr_o,         32'h0000_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
